// File: rtl/mac_operand_feeder_if.sv
// Operand-pair handshake between the feeder and the floating-point MAC.
// The master (feeder) drives the operands and the valid/last qualifiers; the slave (MAC) drives op_ready.
interface mac_operand_feeder_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_last;
  logic             op_ready;

  modport master (
    output op_a,
    output op_b,
    output op_valid,
    output op_last,
    input  op_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_valid,
    input  op_last,
    output op_ready
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// Pops A/B operand words from a 1-cycle-latency FIFO and presents them to the MAC in pairs,
// flagging the final pair of each vector and pulsing done once that pair is accepted.
module mac_operand_feeder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_len,
  input  logic             abort,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rddata,
  output logic             fifo_rden,
  output logic             busy,
  output logic             done,
  mac_operand_feeder_if.master mac
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    CAP_A,
    FETCH_B,
    CAP_B,
    ISSUE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_q;

  assign busy = (state != IDLE);

  // Each FETCH state pops once and then leaves, so a pop can never repeat; abort suppresses the pop.
  assign fifo_rden = ((state == FETCH_A) || (state == FETCH_B)) && !fifo_empty && !abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      count        <= '0;
      len_q        <= '0;
      done         <= 1'b0;
      mac.op_a     <= '0;
      mac.op_b     <= '0;
      mac.op_valid <= 1'b0;
      mac.op_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        count        <= '0;
        mac.op_valid <= 1'b0;
        mac.op_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (vec_len != '0)) begin
              len_q <= vec_len;
              count <= '0;
              state <= FETCH_A;
            end
          end
          FETCH_A: begin
            if (!fifo_empty) state <= CAP_A;
          end
          CAP_A: begin
            mac.op_a <= fifo_rddata;
            state    <= FETCH_B;
          end
          FETCH_B: begin
            if (!fifo_empty) state <= CAP_B;
          end
          CAP_B: begin
            mac.op_b     <= fifo_rddata;
            mac.op_valid <= 1'b1;
            // count stops at len-1, so len up to 2^CNT_W-1 never wraps
            mac.op_last  <= (count == (len_q - CNT_W'(1)));
            state        <= ISSUE;
          end
          ISSUE: begin
            if (mac.op_ready) begin
              mac.op_valid <= 1'b0;
              mac.op_last  <= 1'b0;
              count        <= count + CNT_W'(1);
              if (mac.op_last) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= FETCH_A;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench: a queue-based FIFO model feeds the feeder, and a monitor checks every accepted
// pair against consecutive written words, plus handshake stability, done timing and empty-read safety.
module tb_mac_operand_feeder;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] vec_len = '0;
  logic             abort = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rddata = '0;
  logic             fifo_rden;
  logic             busy;
  logic             done;

  mac_operand_feeder_if #(.WIDTH(WIDTH)) mac_bus ();

  mac_operand_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .vec_len(vec_len), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_rddata(fifo_rddata), .fifo_rden(fifo_rden),
    .busy(busy), .done(done), .mac(mac_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;
  int ready_mode = 0;
  bit done_due = 0;
  bit hold_valid = 0;
  logic [WIDTH-1:0] prev_a, prev_b;
  logic prev_last;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] model_words[$];
  bit exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    model_words.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Expected pairs are simply the next words written to the FIFO, taken two at a time.
  task automatic applyStimulus(input int len, input bit accepted);
    vec_len = CNT_W'(len);
    start = 1'b1;
    if (accepted)
      for (int i = 0; i < len; i++) exp_q.push_back(i == len - 1);
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done_due) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("[TB] FAIL timeout: %0d pairs still pending after %0d cycles", exp_q.size(), n);
    end
  endtask

  // FIFO model with registered read data.
  always @(posedge clk) begin
    if (fifo_rden && fifo_q.size() > 0) begin
      fifo_rddata <= fifo_q.pop_front();
      fifo_empty  <= (fifo_q.size() == 0);
    end
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       mac_bus.op_ready = 1'b1;
      1:       mac_bus.op_ready = 1'($urandom_range(0, 1));
      default: mac_bus.op_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rstn) begin
      hold_valid = 0;
      done_due = 0;
    end else begin
      if (fifo_rden) rd_pulses++;
      if (fifo_empty) checkOutput("rden_when_empty", 32'(fifo_rden), 0);
      if (done_due) begin
        checkOutput("done_pulse", 32'(done), 1);
        done_due = 0;
      end else if (done) begin
        checkOutput("spurious_done", 32'(done), 0);
      end
      if (hold_valid) begin
        checkOutput("hold_valid", 32'(mac_bus.op_valid), 1);
        checkOutput("hold_a", 32'(mac_bus.op_a), 32'(prev_a));
        checkOutput("hold_b", 32'(mac_bus.op_b), 32'(prev_b));
        checkOutput("hold_last", 32'(mac_bus.op_last), 32'(prev_last));
      end
      if (mac_bus.op_valid && mac_bus.op_ready) begin
        hold_valid = 0;
        if (exp_q.size() == 0 || model_words.size() < 2) begin
          checkOutput("unexpected_pair", 1, 0);
        end else begin
          automatic bit exp_last = exp_q.pop_front();
          automatic logic [WIDTH-1:0] exp_a = model_words.pop_front();
          automatic logic [WIDTH-1:0] exp_b = model_words.pop_front();
          checkOutput("op_a", 32'(mac_bus.op_a), 32'(exp_a));
          checkOutput("op_b", 32'(mac_bus.op_b), 32'(exp_b));
          checkOutput("op_last", 32'(mac_bus.op_last), 32'(exp_last));
          if (exp_last) done_due = 1;
        end
      end else if (mac_bus.op_valid) begin
        hold_valid = 1;
        prev_a = mac_bus.op_a;
        prev_b = mac_bus.op_b;
        prev_last = mac_bus.op_last;
      end else begin
        hold_valid = 0;
      end
    end
  end

  initial begin
    int base;
    int n;
    int cnt;
    mac_bus.op_ready = 1'b1;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_rden", 32'(fifo_rden), 0);
    checkOutput("reset_valid", 32'(mac_bus.op_valid), 0);
    checkOutput("reset_last", 32'(mac_bus.op_last), 0);
    checkOutput("reset_a", 32'(mac_bus.op_a), 0);
    checkOutput("reset_b", 32'(mac_bus.op_b), 0);
    rstn = 1'b1;
    tick();

    $display("[TB] single pair");
    ready_mode = 0;
    pushWord(16'h3C00);
    pushWord(16'h4000);
    base = rd_pulses;
    applyStimulus(1, 1);
    waitIdle(50);
    checkOutput("single_rd_pulses", 32'(rd_pulses - base), 2);
    checkOutput("single_busy", 32'(busy), 0);

    $display("[TB] empty stall");
    applyStimulus(2, 1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_rden", 32'(fifo_rden), 0);
      tick();
    end
    for (int i = 0; i < 4; i++) pushWord(16'($urandom));
    waitIdle(100);

    $display("[TB] backpressure");
    ready_mode = 2;
    tick();
    pushWord(16'hA5A5);
    pushWord(16'h5A5A);
    applyStimulus(1, 1);
    n = 0;
    while (!mac_bus.op_valid && n < 20) begin tick(); n++; end
    checkOutput("bp_valid_seen", 32'(mac_bus.op_valid), 1);
    pushWord(16'h1111);
    pushWord(16'h2222);
    base = rd_pulses;
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp_no_rden", 32'(fifo_rden), 0);
      tick();
    end
    checkOutput("bp_pops", 32'(rd_pulses - base), 0);
    ready_mode = 0;
    waitIdle(50);
    applyStimulus(1, 1);
    waitIdle(50);

    $display("[TB] abort");
    ready_mode = 0;
    for (int i = 0; i < 10; i++) pushWord(16'($urandom));
    applyStimulus(5, 1);
    cnt = 0;
    n = 0;
    while (n < 100) begin
      if (fifo_rden) cnt++;
      if (cnt == 6) break;
      tick();
      n++;
    end
    checkOutput("abort_reached_pop6", 32'(cnt), 6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_valid", 32'(mac_bus.op_valid), 0);
    checkOutput("abort_pairs_seen", 32'(exp_q.size()), 3);
    exp_q.delete();
    void'(model_words.pop_front());
    void'(model_words.pop_front());
    repeat (3) tick();
    applyStimulus(1, 1);
    waitIdle(50);
    applyStimulus(1, 1);
    waitIdle(50);

    $display("[TB] ignored start");
    pushWord(16'hBEEF);
    pushWord(16'hCAFE);
    base = rd_pulses;
    applyStimulus(0, 0);
    repeat (5) tick();
    checkOutput("len0_busy", 32'(busy), 0);
    checkOutput("len0_pops", 32'(rd_pulses - base), 0);
    applyStimulus(1, 1);
    waitIdle(50);
    for (int i = 0; i < 6; i++) pushWord(16'($urandom));
    base = rd_pulses;
    applyStimulus(3, 1);
    repeat (3) tick();
    applyStimulus(1, 0);
    waitIdle(100);
    checkOutput("busy_start_pops", 32'(rd_pulses - base), 6);

    $display("[TB] random vectors");
    ready_mode = 1;
    for (int v = 0; v < 8; v++) begin
      automatic int len = $urandom_range(1, 6);
      automatic int pushed = 0;
      applyStimulus(len, 1);
      n = 0;
      while ((pushed < 2 * len || exp_q.size() != 0 || busy || done_due) && n < 600) begin
        if (pushed < 2 * len && $urandom_range(0, 2) == 0) begin
          pushWord(16'($urandom));
          pushed++;
        end
        tick();
        n++;
      end
      checkOutput("random_vector_timeout", 32'(n < 600), 1);
    end

    $display("[TB] reset mid-issue");
    ready_mode = 2;
    tick();
    pushWord(16'h1234);
    pushWord(16'h5678);
    applyStimulus(1, 1);
    n = 0;
    while (!mac_bus.op_valid && n < 20) begin tick(); n++; end
    checkOutput("rst_valid_before", 32'(mac_bus.op_valid), 1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(mac_bus.op_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_rden", 32'(fifo_rden), 0);
    exp_q.delete();
    void'(model_words.pop_front());
    void'(model_words.pop_front());
    tick();
    rstn = 1'b1;
    ready_mode = 0;
    tick();
    checkOutput("rst_idle", 32'(busy), 0);

    $display("[TB] max length");
    for (int i = 0; i < 510; i++) pushWord(16'($urandom));
    base = rd_pulses;
    applyStimulus(255, 1);
    waitIdle(3000);
    checkOutput("max_pops", 32'(rd_pulses - base), 510);
    checkOutput("max_busy", 32'(busy), 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
